// File: rtl/mux_n_to_1_seq.sv
// N:1 multiplexer with a registered, flow-controlled output stage.
// Manual (SEL) or round-robin (scan pointer) channel selection.

// Per-channel request qualifier: channel is a candidate in the upper
// half of the round-robin search (at or above the scan pointer).
module mux_n_to_1_seq_lane #(
  parameter int SELW = 2,
  parameter int IDX  = 0
) (
  input  logic [SELW-1:0] ptr,
  input  logic            valid,
  output logic            req_hi
);
  assign req_hi = valid && (SELW'(IDX) >= ptr);
endmodule

module mux_n_to_1_seq #(
  parameter  int N    = 4,
  parameter  int W    = 1,
  localparam int SELW = $clog2(N)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N*W-1:0]  I,
  input  logic [N-1:0]    I_VALID,
  input  logic [SELW-1:0] SEL,
  input  logic            MODE,
  input  logic            OUT_READY,
  output logic [W-1:0]    OUT,
  output logic            OUT_VALID,
  output logic [SELW-1:0] OUT_CH
);

  logic [SELW-1:0] ptr, ptr_nxt;
  logic [N-1:0]    req_hi;
  logic            hi_found, any_found, sel_ok, grant, load;
  logic [SELW-1:0] hi_idx, any_idx, auto_idx, gidx;
  logic [W-1:0]    gdata;

  for (genvar g = 0; g < N; g++) begin : g_lane
    mux_n_to_1_seq_lane #(.SELW(SELW), .IDX(g)) u_lane (
      .ptr    (ptr),
      .valid  (I_VALID[g]),
      .req_hi (req_hi[g])
    );
  end

  assign load = !OUT_VALID || OUT_READY;

  always_comb begin
    hi_found  = 1'b0;
    any_found = 1'b0;
    hi_idx    = '0;
    any_idx   = '0;
    sel_ok    = 1'b0;
    gdata     = '0;
    // Descending scan so the lowest-numbered match wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (req_hi[k]) begin
        hi_found = 1'b1;
        hi_idx   = SELW'(k);
      end
      if (I_VALID[k]) begin
        any_found = 1'b1;
        any_idx   = SELW'(k);
      end
    end
    // Nothing at/after ptr means the search wrapped to the lowest valid.
    auto_idx = hi_found ? hi_idx : any_idx;

    // SEL values >= N never match a channel, so they read as invalid.
    for (int k = 0; k < N; k++)
      if (SEL == SELW'(k) && I_VALID[k]) sel_ok = 1'b1;

    grant = MODE ? any_found : sel_ok;
    gidx  = MODE ? auto_idx : SEL;

    for (int k = 0; k < N; k++)
      if (gidx == SELW'(k)) gdata = I[k*W +: W];

    ptr_nxt = ptr;
    if (MODE && any_found)
      ptr_nxt = (auto_idx == SELW'(N - 1)) ? '0 : auto_idx + SELW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT       <= '0;
      OUT_VALID <= 1'b0;
      OUT_CH    <= '0;
      ptr       <= '0;
    end else if (load) begin
      OUT_VALID <= grant;
      ptr       <= ptr_nxt;
      if (grant) begin
        OUT    <= gdata;
        OUT_CH <= gidx;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_to_1_seq.sv
// Directed bench for mux_n_to_1_seq: N=4/W=8 main instance plus an N=3
// instance for the non-power-of-two select and wrap cases.
module tb_mux_n_to_1_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] I;
  logic [3:0]  I_VALID;
  logic [1:0]  SEL;
  logic        MODE, OUT_READY;
  logic [7:0]  OUT;
  logic        OUT_VALID;
  logic [1:0]  OUT_CH;

  logic [23:0] i3;
  logic [2:0]  i3_valid;
  logic [1:0]  sel3;
  logic        mode3, ready3;
  logic [7:0]  out3;
  logic        out3_valid;
  logic [1:0]  out3_ch;

  int vec = 0;
  int err = 0;

  always #5 CLK = ~CLK;

  mux_n_to_1_seq #(.N(4), .W(8)) dut (
    .CLK(CLK), .RST(RST), .I(I), .I_VALID(I_VALID), .SEL(SEL), .MODE(MODE),
    .OUT_READY(OUT_READY), .OUT(OUT), .OUT_VALID(OUT_VALID), .OUT_CH(OUT_CH)
  );

  mux_n_to_1_seq #(.N(3), .W(8)) dut3 (
    .CLK(CLK), .RST(RST), .I(i3), .I_VALID(i3_valid), .SEL(sel3), .MODE(mode3),
    .OUT_READY(ready3), .OUT(out3), .OUT_VALID(out3_valid), .OUT_CH(out3_ch)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk4(input string nm, input logic [7:0] d, input logic v, input logic [1:0] ch);
    // Not a shared helper for all tests' logic: just the 3-output probe of the main DUT.
    vec++;
    if (OUT !== d)       begin err++; $display("FAIL %s OUT got %h exp %h", nm, OUT, d); end
    vec++;
    if (OUT_VALID !== v) begin err++; $display("FAIL %s OUT_VALID got %b exp %b", nm, OUT_VALID, v); end
    vec++;
    if (OUT_CH !== ch)   begin err++; $display("FAIL %s OUT_CH got %0d exp %0d", nm, OUT_CH, ch); end
  endtask

  task automatic test_reset();
    RST = 1'b1; I = 32'h44332211; I_VALID = 4'hF; SEL = 2'd2; MODE = 1'b0; OUT_READY = 1'b1;
    i3 = 24'h332211; i3_valid = 3'b000; sel3 = 2'd0; mode3 = 1'b0; ready3 = 1'b1;
    step(); step();
    chk4("reset", 8'h00, 1'b0, 2'd0);
    vec++;
    if (out3_valid !== 1'b0 || out3 !== 8'h00 || out3_ch !== 2'd0) begin
      err++; $display("FAIL reset_n3 got v=%b d=%h ch=%0d exp v=0 d=00 ch=0", out3_valid, out3, out3_ch);
    end
    RST = 1'b0;
  endtask

  task automatic test_manual();
    logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    MODE = 1'b0; OUT_READY = 1'b1; I_VALID = 4'hF;
    for (int s = 0; s < 4; s++) begin
      SEL = 2'(s);
      step();
      chk4($sformatf("manual_sel%0d", s), exp_d[s], 1'b1, 2'(s));
    end
    // Selected channel not valid: valid drops, data/channel retained.
    I_VALID = 4'b1011; SEL = 2'd2;
    step();
    chk4("manual_invalid", 8'h44, 1'b0, 2'd3);
  endtask

  task automatic test_auto_sparse();
    logic [1:0] exp_ch [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    MODE = 1'b1; I_VALID = 4'b1010; SEL = 2'd0; OUT_READY = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step();
      chk4($sformatf("auto_sparse%0d", s), (exp_ch[s] == 2'd1) ? 8'h22 : 8'h44, 1'b1, exp_ch[s]);
    end
  endtask

  task automatic test_back_to_back();
    // ptr is 0 here (last winner was channel 3).
    I_VALID = 4'hF; OUT_READY = 1'b1;
    step();
    chk4("bp_first", 8'h11, 1'b1, 2'd0);
    OUT_READY = 1'b0;
    for (int s = 0; s < 3; s++) begin
      // Inputs churn while the item is held; output must not move.
      I = 32'hDEADBEEF + 32'(s); I_VALID = (s == 1) ? 4'h0 : 4'hE;
      step();
      chk4($sformatf("bp_hold%0d", s), 8'h11, 1'b1, 2'd0);
    end
    I = 32'h44332211; I_VALID = 4'hF; OUT_READY = 1'b1;
    step(); chk4("b2b_0", 8'h22, 1'b1, 2'd1);
    step(); chk4("b2b_1", 8'h33, 1'b1, 2'd2);
    step(); chk4("b2b_2", 8'h44, 1'b1, 2'd3);
    step(); chk4("b2b_3", 8'h11, 1'b1, 2'd0);
  endtask

  task automatic test_idle();
    // ptr is 1 here.
    I_VALID = 4'h0; MODE = 1'b1;
    step(); chk4("idle_auto", 8'h11, 1'b0, 2'd0);
    step(); chk4("idle_auto2", 8'h11, 1'b0, 2'd0);
    MODE = 1'b0; SEL = 2'd1;
    step(); chk4("idle_manual", 8'h11, 1'b0, 2'd0);
    I_VALID = 4'hF; MODE = 1'b1;
    step(); chk4("idle_ptr_kept", 8'h22, 1'b1, 2'd1);
  endtask

  task automatic test_mode_change();
    // ptr is 2 here; manual grant must not disturb it.
    MODE = 1'b0; SEL = 2'd0;
    step(); chk4("mode_manual", 8'h11, 1'b1, 2'd0);
    MODE = 1'b1;
    step(); chk4("mode_auto", 8'h33, 1'b1, 2'd2);
  endtask

  task automatic test_reset_mid();
    // ptr is 3: next grants ch3 then ch0, leaving ptr=1 before reset.
    step(); chk4("pre_rst0", 8'h44, 1'b1, 2'd3);
    step(); chk4("pre_rst1", 8'h11, 1'b1, 2'd0);
    OUT_READY = 1'b0; RST = 1'b1;
    step(); chk4("rst_mid", 8'h00, 1'b0, 2'd0);
    RST = 1'b0; OUT_READY = 1'b1;
    step(); chk4("rst_first_grant", 8'h11, 1'b1, 2'd0);
  endtask

  task automatic test_n3();
    logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h11};
    i3_valid = 3'b111; sel3 = 2'd3; mode3 = 1'b0; ready3 = 1'b1;
    step();
    vec++;
    if (out3_valid !== 1'b0) begin err++; $display("FAIL n3_sel_oob OUT_VALID got %b exp 0", out3_valid); end
    mode3 = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step();
      vec++;
      if (out3_ch !== 2'(s % 3) || out3 !== exp_d[s] || out3_valid !== 1'b1) begin
        err++;
        $display("FAIL n3_auto%0d got ch=%0d d=%h v=%b exp ch=%0d d=%h v=1",
                 s, out3_ch, out3, out3_valid, s % 3, exp_d[s]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_auto_sparse();
    test_back_to_back();
    test_idle();
    test_mode_change();
    test_reset_mid();
    test_n3();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
